fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline, directly upstream of instruction decode.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Captures each returned word plus PC+4 into the IF/ID pipeline register that feeds the decoder and controller.
- Supports decode stalls, branch-delay-slot redirects (branch/J/JAL/JR), and variable-latency memory.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: decode (stall/redirect),
// instruction memory (req/ack), and the IF/ID register outputs.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over req/ack, fills IF/ID,
// and applies branch redirects after the delay slot has been accepted.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc4_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc4_q;
  logic        ifid_valid_q;

  logic [31:0] pc_d;
  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;
  logic        redir_new;
  logic        accept;

  always_comb begin
    pc_inc    = pc_q + 32'd4;
    redir_tgt = bus.redirect_target & ~32'h3;
    redir_new = bus.redirect_valid && !pend_valid_q;
    accept    = 1'b0;
    if (state_q == FETCH && bus.imem_ack && !bus.stall) accept = 1'b1;
    if (state_q == HOLD && !bus.stall)                  accept = 1'b1;
    // A redirect arriving with the delay-slot accept goes straight to the PC.
    if (redir_new)         pc_d = redir_tgt;
    else if (pend_valid_q) pc_d = pend_target_q;
    else                   pc_d = pc_inc;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      hold_instr_q  <= '0;
      hold_pc4_q    <= '0;
      ifid_instr_q  <= '0;
      ifid_pc4_q    <= '0;
      ifid_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            if (!bus.stall) begin
              ifid_instr_q <= bus.imem_rdata;
              ifid_pc4_q   <= pc_inc;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_d;
            end else begin
              hold_instr_q <= bus.imem_rdata;
              hold_pc4_q   <= pc_inc;
              state_q      <= HOLD;
              req_q        <= 1'b0;
            end
          end else if (!bus.stall) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            ifid_instr_q <= hold_instr_q;
            ifid_pc4_q   <= hold_pc4_q;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_d;
            state_q      <= FETCH;
            req_q        <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase

      if (accept) begin
        pend_valid_q <= 1'b0;
      end else if (redir_new) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= redir_tgt;
      end
    end
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus4 = ifid_pc4_q;
  assign bus.ifid_valid    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 0x1000_0000 | address as the instruction.
module tb_fetch_stage;
  logic Clk;
  logic Rst_n;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  assign bus.imem_rdata = 32'h1000_0000 | bus.imem_addr;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic valid, input logic [31:0] instr,
                        input logic [31:0] pc4);
    chk({tag, "_valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
    chk({tag, "_instr"}, bus.ifid_instr, instr);
    chk({tag, "_pc4"}, bus.ifid_pc_plus4, pc4);
  endtask

  task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  // Reset applied between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    Rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk_mem({tag, "_rst"}, 1'b0, 32'h0);
    chk({tag, "_rst_addr"}, bus.imem_addr, 32'h0);
    chk_if({tag, "_rst"}, 1'b0, 32'h0, 32'h0);
    #1;
    Rst_n = 1'b1;
    #1;
    chk_mem({tag, "_boot"}, 1'b0, 32'h0);
    tick();
    chk_mem({tag, "_fetch0"}, 1'b1, 32'h0);
    chk_if({tag, "_fetch0"}, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus.imem_ack = 1'b0;
    Rst_n = 1'b0;
    #1;

    // 1: zero-wait streaming
    do_reset("t1");
    bus.imem_ack = 1'b1;
    tick(); chk_mem("t1_a", 1'b1, 32'h4); chk_if("t1_a", 1'b1, 32'h1000_0000, 32'h4);
    tick(); chk_mem("t1_b", 1'b1, 32'h8); chk_if("t1_b", 1'b1, 32'h1000_0004, 32'h8);
    tick(); chk_mem("t1_c", 1'b1, 32'hC); chk_if("t1_c", 1'b1, 32'h1000_0008, 32'hC);

    // 2: slow memory on 0x4
    do_reset("t2");
    bus.imem_ack = 1'b1;
    tick(); chk_mem("t2_a", 1'b1, 32'h4);
    bus.imem_ack = 1'b0;
    tick(); chk_mem("t2_w1", 1'b1, 32'h4); chk_if("t2_w1", 1'b0, 32'h0, 32'h4);
    tick(); chk_mem("t2_w2", 1'b1, 32'h4); chk_if("t2_w2", 1'b0, 32'h0, 32'h4);
    bus.imem_ack = 1'b1;
    tick(); chk_mem("t2_d", 1'b1, 32'h8); chk_if("t2_d", 1'b1, 32'h1000_0004, 32'h8);

    // 3: stall while 0x10 acks
    tick(); tick();
    chk_mem("t3_pre", 1'b1, 32'h10); chk_if("t3_pre", 1'b1, 32'h1000_000C, 32'h10);
    bus.stall = 1'b1;
    tick(); chk_mem("t3_h1", 1'b0, 32'h0); chk_if("t3_h1", 1'b1, 32'h1000_000C, 32'h10);
    tick(); chk_mem("t3_h2", 1'b0, 32'h0); chk_if("t3_h2", 1'b1, 32'h1000_000C, 32'h10);
    tick(); chk_mem("t3_h3", 1'b0, 32'h0); chk_if("t3_h3", 1'b1, 32'h1000_000C, 32'h10);
    bus.stall = 1'b0;
    tick(); chk_mem("t3_rel", 1'b1, 32'h14); chk_if("t3_rel", 1'b1, 32'h1000_0010, 32'h14);
    // stall with no ack holds IF/ID rather than inserting a bubble
    bus.imem_ack = 1'b0;
    bus.stall = 1'b1;
    tick(); chk_mem("t3_sw", 1'b1, 32'h14); chk_if("t3_sw", 1'b1, 32'h1000_0010, 32'h14);
    bus.stall = 1'b0;
    tick(); chk_if("t3_bub", 1'b0, 32'h0, 32'h14);

    // 4: redirect while delay slot 0x8 is waiting
    do_reset("t4");
    bus.imem_ack = 1'b1;
    tick(); tick(); chk_mem("t4_a", 1'b1, 32'h8);
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h40;
    tick(); chk_mem("t4_w1", 1'b1, 32'h8);
    bus.redirect_valid = 1'b0;
    tick(); chk_mem("t4_w2", 1'b1, 32'h8);
    bus.imem_ack = 1'b1;
    tick(); chk_mem("t4_ds", 1'b1, 32'h40); chk_if("t4_ds", 1'b1, 32'h1000_0008, 32'hC);
    tick(); chk_mem("t4_tg", 1'b1, 32'h44); chk_if("t4_tg", 1'b1, 32'h1000_0040, 32'h44);

    // 5: redirects while held; first wins, then same-cycle bypass with unaligned target
    bus.stall = 1'b1;
    tick(); chk_mem("t5_h", 1'b0, 32'h0); chk_if("t5_h", 1'b1, 32'h1000_0040, 32'h44);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h80;
    tick();
    bus.redirect_target = 32'hC0;
    tick();
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    tick(); chk_mem("t5_rel", 1'b1, 32'h80); chk_if("t5_rel", 1'b1, 32'h1000_0044, 32'h48);
    tick(); chk_mem("t5_no_c0", 1'b1, 32'h84); chk_if("t5_80", 1'b1, 32'h1000_0080, 32'h84);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h103;
    tick(); chk_mem("t5_byp", 1'b1, 32'h100); chk_if("t5_byp", 1'b1, 32'h1000_0084, 32'h88);
    bus.redirect_valid = 1'b0;
    tick(); chk_mem("t5_seq", 1'b1, 32'h104); chk_if("t5_seq", 1'b1, 32'h1000_0100, 32'h104);

    // 6: reset mid-wait, redirect during BOOT, PC wrap
    bus.imem_ack = 1'b0;
    tick(); chk_mem("t6_wait", 1'b1, 32'h104);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_mem("t6_async", 1'b0, 32'h0);
    chk({"t6_async_addr"}, bus.imem_addr, 32'h0);
    chk_if("t6_async", 1'b0, 32'h0, 32'h0);
    #1;
    Rst_n = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk_mem("t6_f0", 1'b1, 32'h0); chk_if("t6_f0", 1'b0, 32'h0, 32'h0);
    tick(); chk_if("t6_noack", 1'b0, 32'h0, 32'h0);
    bus.imem_ack = 1'b1;
    tick(); chk_mem("t6_tgt", 1'b1, 32'hFFFF_FFFC); chk_if("t6_ds", 1'b1, 32'h1000_0000, 32'h4);
    tick(); chk_mem("t6_wrap", 1'b1, 32'h0); chk_if("t6_wrap", 1'b1, 32'hFFFF_FFFC, 32'h0);
    bus.imem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
